// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// Multi-cycle sequencer for the 18-bit CPU datapath. A five-state FSM
// (FETCH, DECODE, EXEC, MEM, WB, plus an optional HALT) decodes the opcode
// in instruction[17:14] and drives the datapath strobes. Data-memory
// accesses wait in MEM for memReady, with a bounded timeout that sets a
// sticky memError.
//
// Optional feature macro: CONTROL_UNIT_HALT_EN
//   defined   -> opcode 1111 enters HALT until reset
//   undefined -> opcode 1111 behaves as a NOP, HALT is unreachable
//
// Parameters:
//   MEM_TIMEOUT   max cycles spent in MEM waiting for memReady (1..255)
//
// Ports:
//   clock              in   rising-edge clock
//   resetControlUnit   in   synchronous active-low reset
//   instruction[17:0]  in   instruction register contents
//   zeroFlag           in   ALU compare: SRC1 == SRC2
//   negFlag            in   ALU compare: SRC1 <  SRC2 (signed)
//   memReady           in   data memory finished current load/store
//   instRead, pcRead   out  fetch strobes
//   pcIncrement        out  PC <= PC+1
//   pcLoad             out  PC <= jump/branch target
//   immSignal, registerWrite, memLoad, memStore,
//   compare, branch, jumpSig   out  datapath controls
//   aluControl[1:0]    out  00 AND, 01 ADD, 10 OR, 11 XOR
//   memError           out  sticky MEM timeout flag
//   state[2:0]         out  FSM state (debug)
// ---------------------------------------------------------------------------
module control_unit #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        resetControlUnit,
  input  logic [17:0] instruction,
  input  logic        zeroFlag,
  input  logic        negFlag,
  input  logic        memReady,
  output logic        instRead,
  output logic        pcRead,
  output logic        pcIncrement,
  output logic        pcLoad,
  output logic        immSignal,
  output logic        registerWrite,
  output logic        memLoad,
  output logic        memStore,
  output logic        compare,
  output logic        branch,
  output logic        jumpSig,
  output logic [1:0]  aluControl,
  output logic        memError,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_LD   = 4'b1000;
  localparam logic [3:0] OP_ST   = 4'b1001;
  localparam logic [3:0] OP_JUMP = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_BLT  = 4'b1100;
`ifdef CONTROL_UNIT_HALT_EN
  localparam logic [3:0] OP_HALT = 4'b1111;
`endif

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [7:0] wait_q, wait_d;
  logic       mem_error_q, mem_error_d;

  // Only the opcode field matters to sequencing; operand bits go to the
  // datapath directly.
  logic unused_operand_bits;
  assign unused_operand_bits = ^instruction[13:0];

  // Next-state, opcode latch, wait counter and sticky error.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wait_d      = wait_q;
    mem_error_d = mem_error_q;

    case (state_q)
      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        // Later states use this copy so the instruction register may change.
        op_d    = instruction[17:14];
        state_d = S_EXEC;
      end

      S_EXEC: begin
        if (!op_q[3]) begin
          state_d = S_WB;
        end else begin
          case (op_q)
            OP_LD, OP_ST: begin
              // Counter holds the number of MEM cycles including the current
              // one, so the first MEM cycle sees 1.
              state_d = S_MEM;
              wait_d  = 8'd1;
            end
`ifdef CONTROL_UNIT_HALT_EN
            OP_HALT: state_d = S_HALT;
`endif
            default: state_d = S_FETCH;
          endcase
        end
      end

      S_MEM: begin
        // memReady on the timeout cycle still counts as a normal completion.
        if (memReady) begin
          state_d = (op_q == OP_LD) ? S_WB : S_FETCH;
        end else if (wait_q == TIMEOUT) begin
          state_d     = S_FETCH;
          mem_error_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetControlUnit) begin
      state_q     <= S_FETCH;
      op_q        <= 4'd0;
      wait_q      <= 8'd0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wait_q      <= wait_d;
      mem_error_q <= mem_error_d;
    end
  end

  // Moore decode from registered state and latched opcode; only pcLoad in
  // EXEC looks at the live compare flags.
  always_comb begin
    instRead      = 1'b0;
    pcRead        = 1'b0;
    pcIncrement   = 1'b0;
    pcLoad        = 1'b0;
    immSignal     = 1'b0;
    registerWrite = 1'b0;
    memLoad       = 1'b0;
    memStore      = 1'b0;
    compare       = 1'b0;
    branch        = 1'b0;
    jumpSig       = 1'b0;
    aluControl    = 2'b00;

    case (state_q)
      S_FETCH: begin
        instRead    = 1'b1;
        pcRead      = 1'b1;
        pcIncrement = 1'b1;
      end

      S_EXEC: begin
        if (!op_q[3]) begin
          // ALU opcodes: bits [2:1] select the operation, bit 0 the immediate.
          aluControl = op_q[2:1];
          immSignal  = op_q[0];
        end else begin
          case (op_q)
            OP_LD, OP_ST: aluControl = 2'b01;
            OP_JUMP: begin
              jumpSig = 1'b1;
              pcLoad  = 1'b1;
            end
            OP_BEQ: begin
              compare    = 1'b1;
              branch     = 1'b1;
              aluControl = 2'b01;
              pcLoad     = zeroFlag;
            end
            OP_BLT: begin
              compare    = 1'b1;
              branch     = 1'b1;
              aluControl = 2'b01;
              pcLoad     = negFlag;
            end
            default: ;
          endcase
        end
      end

      S_MEM: begin
        memLoad  = (op_q == OP_LD);
        memStore = (op_q == OP_ST);
      end

      S_WB: begin
        registerWrite = 1'b1;
        // Keeps the register-file write mux on memory data for loads.
        memLoad       = (op_q == OP_LD);
      end

      default: ;
    endcase
  end

  assign memError = mem_error_q;
  assign state    = state_q;

endmodule
